// File: rtl/cpu_types_pkg.sv
// Shared CPU pipeline types: register index, hazard FSM states, forwarding selects.
package cpu_types_pkg;

    localparam int unsigned REG_W = 5;

    typedef logic [REG_W-1:0] regbits_t;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        MEMWAIT = 2'd1,
        LDUSE   = 2'd2,
        HALT    = 2'd3
    } hz_state_t;

    typedef enum logic [1:0] {
        FWD_NONE  = 2'b00,
        FWD_MEMWB = 2'b01,
        FWD_EXMEM = 2'b10
    } fwd_t;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline-state inputs and latch-control outputs of the hazard controller.
interface hazard_ctrl_if #(
    parameter int unsigned CNT_W = 32
);
    import cpu_types_pkg::*;

    logic             ihit, dhit;
    regbits_t         ifid_rs, ifid_rt;
    regbits_t         idex_rs, idex_rt, idex_writeReg;
    logic             idex_dMemREN, idex_regWEN;
    regbits_t         exmem_writeReg;
    logic             exmem_regWEN, exmem_dMemREN, exmem_dMemWEN, exmem_Halt;
    regbits_t         memwb_writeReg;
    logic             memwb_regWEN;
    logic             branch_taken, jump;

    logic             pc_en;
    logic             ifid_writeEN, ifid_flush;
    logic             idex_writeEN, idex_flush;
    logic             exmem_writeEN, exmem_flush;
    logic             memwb_writeEN;
    fwd_t             fwdA, fwdB;
    logic             halted;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    // Pipeline side: presents stage state, consumes latch controls.
    modport master (
        output ihit, dhit, ifid_rs, ifid_rt, idex_rs, idex_rt, idex_writeReg,
               idex_dMemREN, idex_regWEN, exmem_writeReg, exmem_regWEN,
               exmem_dMemREN, exmem_dMemWEN, exmem_Halt, memwb_writeReg,
               memwb_regWEN, branch_taken, jump,
        input  pc_en, ifid_writeEN, ifid_flush, idex_writeEN, idex_flush,
               exmem_writeEN, exmem_flush, memwb_writeEN, fwdA, fwdB, halted,
               stall_cnt, flush_cnt
    );

    // Hazard controller side.
    modport slave (
        input  ihit, dhit, ifid_rs, ifid_rt, idex_rs, idex_rt, idex_writeReg,
               idex_dMemREN, idex_regWEN, exmem_writeReg, exmem_regWEN,
               exmem_dMemREN, exmem_dMemWEN, exmem_Halt, memwb_writeReg,
               memwb_regWEN, branch_taken, jump,
        output pc_en, ifid_writeEN, ifid_flush, idex_writeEN, idex_flush,
               exmem_writeEN, exmem_flush, memwb_writeEN, fwdA, fwdB, halted,
               stall_cnt, flush_cnt
    );

endinterface

// File: rtl/fwd_unit.sv
// EX-stage forwarding select for one source operand; $0 is never forwarded.
module fwd_unit
    import cpu_types_pkg::*;
(
    input  regbits_t i_src,
    input  regbits_t i_exmem_reg,
    input  logic     i_exmem_wen,
    input  regbits_t i_memwb_reg,
    input  logic     i_memwb_wen,
    output fwd_t     o_fwd_c
);

    // Youngest producer (EX/MEM) wins over MEM/WB.
    always_comb begin
        o_fwd_c = FWD_NONE;
        if (i_exmem_wen && (i_exmem_reg != regbits_t'(0)) && (i_exmem_reg == i_src)) begin
            o_fwd_c = FWD_EXMEM;
        end else if (i_memwb_wen && (i_memwb_reg != regbits_t'(0)) && (i_memwb_reg == i_src)) begin
            o_fwd_c = FWD_MEMWB;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: latch enables/flushes, PC enable, forwarding selects.
// Optional performance counters built when HAZARD_PERF_CNT_EN is defined.
module hazard_ctrl
    import cpu_types_pkg::*;
#(
    parameter int unsigned LDUSE_BUBBLES = 1,
    parameter int unsigned CNT_W         = 32
) (
    input  logic CLK,
    input  logic nRST,
    hazard_ctrl_if.slave bus
);

    hz_state_t r_state, w_next;
    logic      r_bub_pend, w_bub_next;
    logic      r_halted;

    logic w_pc_en, w_ifid_wen, w_idex_wen, w_exmem_wen, w_memwb_wen;
    logic w_ifid_flush, w_idex_flush, w_exmem_flush;
    logic w_freeze, w_flow, w_redir_cyc;
    logic w_mem_pend, w_memwait, w_redirect, w_lduse;
    fwd_t w_fwd_a, w_fwd_b;

    assign w_mem_pend = bus.exmem_dMemREN | bus.exmem_dMemWEN;
    assign w_memwait  = w_mem_pend & ~bus.dhit;
    assign w_redirect = bus.branch_taken | bus.jump;
    assign w_lduse    = bus.idex_dMemREN && (bus.idex_writeReg != regbits_t'(0)) &&
                        ((bus.idex_writeReg == bus.ifid_rs) || (bus.idex_writeReg == bus.ifid_rt));

    // State, pending-bubble flag and halt flag.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            r_state    <= RUN;
            r_bub_pend <= 1'b0;
            r_halted   <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_bub_pend <= w_bub_next;
            r_halted   <= (w_next == HALT);
        end
    end

    // Next state and raw latch controls; r_bub_pend remembers an LDUSE bubble interrupted by a miss.
    always_comb begin
        w_next        = r_state;
        w_bub_next    = r_bub_pend;
        w_pc_en       = 1'b1;
        w_ifid_wen    = 1'b1;
        w_idex_wen    = 1'b1;
        w_exmem_wen   = 1'b1;
        w_memwb_wen   = 1'b1;
        w_ifid_flush  = 1'b0;
        w_idex_flush  = 1'b0;
        w_exmem_flush = 1'b0;
        w_freeze      = 1'b0;
        w_flow        = 1'b0;
        w_redir_cyc   = 1'b0;
        case (r_state)
            RUN: begin
                if (bus.exmem_Halt && !w_mem_pend) begin
                    w_freeze = 1'b1;
                    w_next   = HALT;
                end else if (w_memwait) begin
                    w_freeze = 1'b1;
                    w_next   = MEMWAIT;
                end else begin
                    w_flow = 1'b1;
                end
            end
            MEMWAIT: begin
                if (w_memwait) begin
                    w_freeze = 1'b1;
                end else if (r_bub_pend) begin
                    w_pc_en      = bus.ihit;
                    w_ifid_flush = ~bus.ihit;
                    w_bub_next   = 1'b0;
                    w_next       = LDUSE;
                end else begin
                    w_next = RUN;
                    w_flow = 1'b1;
                end
            end
            LDUSE: begin
                if (w_memwait) begin
                    w_freeze   = 1'b1;
                    w_bub_next = 1'b1;
                    w_next     = MEMWAIT;
                end else begin
                    w_pc_en      = 1'b0;
                    w_ifid_wen   = 1'b0;
                    w_idex_flush = 1'b1;
                    w_next       = RUN;
                end
            end
            HALT: begin
                w_freeze = 1'b1;
            end
            default: begin
                w_next = RUN;
            end
        endcase

        // Redirect beats load-use: the wrong-path decode instruction is discarded anyway.
        if (w_flow) begin
            if (w_redirect) begin
                w_ifid_flush = 1'b1;
                w_idex_flush = 1'b1;
                w_redir_cyc  = 1'b1;
            end else if (w_lduse) begin
                w_pc_en      = 1'b0;
                w_ifid_wen   = 1'b0;
                w_idex_flush = 1'b1;
                if (LDUSE_BUBBLES > 1) begin
                    w_next = LDUSE;
                end
            end else if (!bus.ihit) begin
                w_pc_en      = 1'b0;
                w_ifid_flush = 1'b1;
            end
        end

        if (w_freeze) begin
            w_pc_en     = 1'b0;
            w_ifid_wen  = 1'b0;
            w_idex_wen  = 1'b0;
            w_exmem_wen = 1'b0;
            w_memwb_wen = 1'b0;
        end
    end

    fwd_unit u_fwd_rs (
        .i_src       (bus.idex_rs),
        .i_exmem_reg (bus.exmem_writeReg),
        .i_exmem_wen (bus.exmem_regWEN),
        .i_memwb_reg (bus.memwb_writeReg),
        .i_memwb_wen (bus.memwb_regWEN),
        .o_fwd_c     (w_fwd_a)
    );

    fwd_unit u_fwd_rt (
        .i_src       (bus.idex_rt),
        .i_exmem_reg (bus.exmem_writeReg),
        .i_exmem_wen (bus.exmem_regWEN),
        .i_memwb_reg (bus.memwb_writeReg),
        .i_memwb_wen (bus.memwb_regWEN),
        .o_fwd_c     (w_fwd_b)
    );

    // While reset is asserted every latch is flushed and held.
    assign bus.pc_en         = nRST & w_pc_en;
    assign bus.ifid_writeEN  = nRST & w_ifid_wen;
    assign bus.idex_writeEN  = nRST & w_idex_wen;
    assign bus.exmem_writeEN = nRST & w_exmem_wen;
    assign bus.memwb_writeEN = nRST & w_memwb_wen;
    assign bus.ifid_flush    = ~nRST | w_ifid_flush;
    assign bus.idex_flush    = ~nRST | w_idex_flush;
    assign bus.exmem_flush   = ~nRST | w_exmem_flush;
    assign bus.fwdA          = nRST ? w_fwd_a : FWD_NONE;
    assign bus.fwdB          = nRST ? w_fwd_b : FWD_NONE;
    assign bus.halted        = r_halted;

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] r_stall_cnt, r_flush_cnt;

    // Stall and redirect event counters, wrapping at 2^CNT_W.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            r_stall_cnt <= CNT_W'(0);
            r_flush_cnt <= CNT_W'(0);
        end else begin
            if (!w_pc_en && (r_state != HALT)) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
            if (w_redir_cyc) begin
                r_flush_cnt <= r_flush_cnt + CNT_W'(1);
            end
        end
    end

    assign bus.stall_cnt = r_stall_cnt;
    assign bus.flush_cnt = r_flush_cnt;
`else
    logic w_unused_cnt;
    assign w_unused_cnt  = w_redir_cyc;
    assign bus.stall_cnt = CNT_W'(0);
    assign bus.flush_cnt = CNT_W'(0);
`endif

    logic w_unused_in;
    assign w_unused_in = bus.idex_regWEN;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios plus randomized run against a reference model.
module tb_hazard_ctrl;
    import cpu_types_pkg::*;

    localparam int unsigned CNT_W = 4;
`ifdef HAZARD_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    // {pc_en, ifid_wen, ifid_flush, idex_wen, idex_flush, exmem_wen, exmem_flush, memwb_wen}
    localparam logic [7:0] C_IDLE    = 8'b1101_0101;
    localparam logic [7:0] C_BUB     = 8'b0001_1101;
    localparam logic [7:0] C_FREEZE  = 8'b0000_0000;
    localparam logic [7:0] C_RST     = 8'b0010_1010;
    localparam logic [7:0] C_REDIR   = 8'b1111_1101;
    localparam logic [7:0] C_NOFETCH = 8'b0111_0101;

    logic CLK  = 1'b0;
    logic nRST = 1'b0;
    int   n_checks = 0;
    int   n_pass   = 0;

    always #5 CLK = ~CLK;

    hazard_ctrl_if #(.CNT_W(CNT_W)) bus ();
    hazard_ctrl_if #(.CNT_W(CNT_W)) bus2 ();

    hazard_ctrl #(.LDUSE_BUBBLES(1), .CNT_W(CNT_W)) u_dut  (.CLK(CLK), .nRST(nRST), .bus(bus));
    hazard_ctrl #(.LDUSE_BUBBLES(2), .CNT_W(CNT_W)) u_dut2 (.CLK(CLK), .nRST(nRST), .bus(bus2));

    assign bus2.ihit           = bus.ihit;
    assign bus2.dhit           = bus.dhit;
    assign bus2.ifid_rs        = bus.ifid_rs;
    assign bus2.ifid_rt        = bus.ifid_rt;
    assign bus2.idex_rs        = bus.idex_rs;
    assign bus2.idex_rt        = bus.idex_rt;
    assign bus2.idex_writeReg  = bus.idex_writeReg;
    assign bus2.idex_dMemREN   = bus.idex_dMemREN;
    assign bus2.idex_regWEN    = bus.idex_regWEN;
    assign bus2.exmem_writeReg = bus.exmem_writeReg;
    assign bus2.exmem_regWEN   = bus.exmem_regWEN;
    assign bus2.exmem_dMemREN  = bus.exmem_dMemREN;
    assign bus2.exmem_dMemWEN  = bus.exmem_dMemWEN;
    assign bus2.exmem_Halt     = bus.exmem_Halt;
    assign bus2.memwb_writeReg = bus.memwb_writeReg;
    assign bus2.memwb_regWEN   = bus.memwb_regWEN;
    assign bus2.branch_taken   = bus.branch_taken;
    assign bus2.jump           = bus.jump;

    function automatic logic [7:0] get_ctl(input int k);
        if (k == 0)
            return {bus.pc_en, bus.ifid_writeEN, bus.ifid_flush, bus.idex_writeEN,
                    bus.idex_flush, bus.exmem_writeEN, bus.exmem_flush, bus.memwb_writeEN};
        return {bus2.pc_en, bus2.ifid_writeEN, bus2.ifid_flush, bus2.idex_writeEN,
                bus2.idex_flush, bus2.exmem_writeEN, bus2.exmem_flush, bus2.memwb_writeEN};
    endfunction

    // {halted, stall_cnt, flush_cnt}
    function automatic logic [2*CNT_W:0] get_stat(input int k);
        if (k == 0) return {bus.halted, bus.stall_cnt, bus.flush_cnt};
        return {bus2.halted, bus2.stall_cnt, bus2.flush_cnt};
    endfunction

    function automatic fwd_t ref_fwd(input regbits_t src, input regbits_t exwr, input logic exen,
                                     input regbits_t mwwr, input logic mwen);
        if (src == 5'd0) return FWD_NONE;
        if (exen && exwr == src) return FWD_EXMEM;
        if (mwen && mwwr == src) return FWD_MEMWB;
        return FWD_NONE;
    endfunction

    task automatic set_idle();
        bus.ihit = 1'b1; bus.dhit = 1'b1;
        bus.ifid_rs = '0; bus.ifid_rt = '0;
        bus.idex_rs = '0; bus.idex_rt = '0; bus.idex_writeReg = '0;
        bus.idex_dMemREN = 1'b0; bus.idex_regWEN = 1'b0;
        bus.exmem_writeReg = '0; bus.exmem_regWEN = 1'b0;
        bus.exmem_dMemREN = 1'b0; bus.exmem_dMemWEN = 1'b0; bus.exmem_Halt = 1'b0;
        bus.memwb_writeReg = '0; bus.memwb_regWEN = 1'b0;
        bus.branch_taken = 1'b0; bus.jump = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge CLK);
        nRST = 1'b0;
        set_idle();
        @(negedge CLK);
        nRST = 1'b1;
    endtask

    task automatic test_reset();
        logic [2*CNT_W:0] st;
        nRST = 1'b0;
        set_idle();
        bus.idex_rs = 5'd3; bus.exmem_writeReg = 5'd3; bus.exmem_regWEN = 1'b1;
        bus.idex_dMemREN = 1'b1; bus.idex_writeReg = 5'd4; bus.ifid_rs = 5'd4;
        @(negedge CLK); #1;
        n_checks++;
        if (get_ctl(0) !== C_RST) $display("FAIL reset_ctl: got %b need %b", get_ctl(0), C_RST);
        else n_pass++;
        n_checks++;
        if (bus.fwdA !== FWD_NONE) $display("FAIL reset_fwdA: got %b need %b", bus.fwdA, FWD_NONE);
        else n_pass++;
        set_idle();
        bus.idex_rs = 5'd3; bus.exmem_writeReg = 5'd3; bus.exmem_regWEN = 1'b1;
        nRST = 1'b1;
        #1;
        st = get_stat(0);
        n_checks++;
        if (st !== '0) $display("FAIL reset_state: got halted/stall/flush %h need 0", st);
        else n_pass++;
        n_checks++;
        if (get_ctl(0) !== C_IDLE) $display("FAIL post_reset_ctl: got %b need %b", get_ctl(0), C_IDLE);
        else n_pass++;
        n_checks++;
        if (bus.fwdA !== FWD_EXMEM) $display("FAIL post_reset_fwdA: got %b need %b", bus.fwdA, FWD_EXMEM);
        else n_pass++;
    endtask

    task automatic test_load_use();
        do_reset();
        @(negedge CLK);
        bus.idex_dMemREN = 1'b1; bus.idex_writeReg = 5'd8; bus.idex_regWEN = 1'b1; bus.ifid_rs = 5'd8;
        #1;
        n_checks++;
        if (get_ctl(0) !== C_BUB) $display("FAIL lduse_bubble: got %b need %b", get_ctl(0), C_BUB);
        else n_pass++;
        n_checks++;
        if (get_ctl(1) !== C_BUB) $display("FAIL lduse_bubble_b2: got %b need %b", get_ctl(1), C_BUB);
        else n_pass++;
        @(negedge CLK);
        set_idle();
        bus.idex_rs = 5'd8; bus.ifid_rs = 5'd8; bus.memwb_writeReg = 5'd8; bus.memwb_regWEN = 1'b1;
        #1;
        n_checks++;
        if (get_ctl(0) !== C_IDLE) $display("FAIL lduse_resume: got %b need %b", get_ctl(0), C_IDLE);
        else n_pass++;
        n_checks++;
        if (bus.fwdA !== FWD_MEMWB) $display("FAIL lduse_fwdA: got %b need %b", bus.fwdA, FWD_MEMWB);
        else n_pass++;
        n_checks++;
        if (get_ctl(1) !== C_BUB) $display("FAIL lduse_second_bubble_b2: got %b need %b", get_ctl(1), C_BUB);
        else n_pass++;
        @(negedge CLK); #1;
        n_checks++;
        if (get_ctl(1) !== C_IDLE) $display("FAIL lduse_resume_b2: got %b need %b", get_ctl(1), C_IDLE);
        else n_pass++;
    endtask

    task automatic test_mem_wait();
        do_reset();
        for (int c = 0; c < 3; c++) begin
            @(negedge CLK);
            bus.exmem_dMemREN = 1'b1; bus.dhit = 1'b0;
            #1;
            n_checks++;
            if (get_ctl(0) !== C_FREEZE) $display("FAIL memwait_hold[%0d]: got %b need %b", c, get_ctl(0), C_FREEZE);
            else n_pass++;
        end
        @(negedge CLK);
        bus.dhit = 1'b1;
        #1;
        n_checks++;
        if (get_ctl(0) !== C_IDLE) $display("FAIL memwait_release: got %b need %b", get_ctl(0), C_IDLE);
        else n_pass++;
        @(negedge CLK);
        set_idle();
        #1;
        n_checks++;
        if (get_ctl(0) !== C_IDLE) $display("FAIL memwait_after: got %b need %b", get_ctl(0), C_IDLE);
        else n_pass++;
    endtask

    task automatic test_redirect_vs_lduse();
        do_reset();
        @(negedge CLK);
        bus.branch_taken = 1'b1;
        bus.idex_dMemREN = 1'b1; bus.idex_writeReg = 5'd9; bus.ifid_rt = 5'd9;
        #1;
        n_checks++;
        if (get_ctl(0) !== C_REDIR) $display("FAIL redirect_over_lduse: got %b need %b", get_ctl(0), C_REDIR);
        else n_pass++;
        @(negedge CLK);
        set_idle();
        #1;
        n_checks++;
        if (get_ctl(1) !== C_IDLE) $display("FAIL redirect_no_lduse_b2: got %b need %b", get_ctl(1), C_IDLE);
        else n_pass++;
    endtask

    task automatic test_fwd_priority();
        @(negedge CLK);
        set_idle();
        bus.exmem_writeReg = 5'd5; bus.exmem_regWEN = 1'b1;
        bus.memwb_writeReg = 5'd5; bus.memwb_regWEN = 1'b1;
        bus.idex_rs = 5'd5; bus.idex_rt = 5'd0;
        #1;
        n_checks++;
        if (bus.fwdA !== FWD_EXMEM) $display("FAIL fwd_exmem_wins: got %b need %b", bus.fwdA, FWD_EXMEM);
        else n_pass++;
        n_checks++;
        if (bus.fwdB !== FWD_NONE) $display("FAIL fwd_rt_none: got %b need %b", bus.fwdB, FWD_NONE);
        else n_pass++;
        bus.exmem_writeReg = 5'd0; bus.memwb_writeReg = 5'd0; bus.idex_rs = 5'd0;
        #1;
        n_checks++;
        if (bus.fwdA !== FWD_NONE) $display("FAIL fwd_r0: got %b need %b", bus.fwdA, FWD_NONE);
        else n_pass++;
        bus.exmem_writeReg = 5'd6; bus.exmem_regWEN = 1'b0; bus.memwb_writeReg = 5'd6; bus.idex_rt = 5'd6;
        #1;
        n_checks++;
        if (bus.fwdB !== FWD_MEMWB) $display("FAIL fwd_memwb: got %b need %b", bus.fwdB, FWD_MEMWB);
        else n_pass++;
    endtask

    task automatic test_halt();
        do_reset();
        @(negedge CLK);
        bus.exmem_Halt = 1'b1;
        #1;
        n_checks++;
        if ({get_ctl(0), bus.halted} !== {C_FREEZE, 1'b0})
            $display("FAIL halt_entry: got ctl %b halted %b need %b 0", get_ctl(0), bus.halted, C_FREEZE);
        else n_pass++;
        for (int c = 0; c < 10; c++) begin
            @(negedge CLK);
            set_idle();
            #1;
            n_checks++;
            if ({get_ctl(0), bus.halted} !== {C_FREEZE, 1'b1})
                $display("FAIL halt_hold[%0d]: got ctl %b halted %b need %b 1", c, get_ctl(0), bus.halted, C_FREEZE);
            else n_pass++;
        end
        @(negedge CLK);
        nRST = 1'b0;
        #1;
        n_checks++;
        if (get_ctl(0) !== C_RST) $display("FAIL halt_reset_ctl: got %b need %b", get_ctl(0), C_RST);
        else n_pass++;
        @(negedge CLK);
        nRST = 1'b1;
        #1;
        n_checks++;
        if ({get_ctl(0), get_stat(0)} !== {C_IDLE, 9'd0})
            $display("FAIL halt_exit: got ctl %b stat %h need %b 0", get_ctl(0), get_stat(0), C_IDLE);
        else n_pass++;
    endtask

    task automatic test_counters();
        logic [CNT_W-1:0] exp_s, exp_f;
        do_reset();
        for (int c = 0; c < 4; c++) begin
            @(negedge CLK); set_idle(); bus.ihit = 1'b0;
        end
        for (int c = 0; c < 2; c++) begin
            @(negedge CLK); set_idle(); bus.jump = 1'b1;
        end
        @(negedge CLK); set_idle(); #1;
        exp_s = PERF ? CNT_W'(4) : CNT_W'(0);
        exp_f = PERF ? CNT_W'(2) : CNT_W'(0);
        n_checks++;
        if ({bus.stall_cnt, bus.flush_cnt} !== {exp_s, exp_f})
            $display("FAIL cnt_basic: got stall %0d flush %0d need %0d %0d", bus.stall_cnt, bus.flush_cnt, exp_s, exp_f);
        else n_pass++;
        for (int c = 0; c < 12; c++) begin
            @(negedge CLK); set_idle(); bus.ihit = 1'b0;
        end
        @(negedge CLK); set_idle(); #1;
        n_checks++;
        if ({bus.stall_cnt, bus.flush_cnt} !== {CNT_W'(0), exp_f})
            $display("FAIL cnt_wrap: got stall %0d flush %0d need 0 %0d", bus.stall_cnt, bus.flush_cnt, exp_f);
        else n_pass++;
    endtask

    task automatic test_random();
        int       m_halt[2], m_wait[2], m_owed[2], m_stall[2], m_flush[2];
        logic [7:0]       e;
        logic [2*CNT_W:0] st, est;
        logic     pend, miss, redir, ld;
        do_reset();
        for (int k = 0; k < 2; k++) begin
            m_halt[k] = 0; m_wait[k] = 0; m_owed[k] = 0; m_stall[k] = 0; m_flush[k] = 0;
        end
        for (int i = 0; i < 400; i++) begin
            if (i % 64 == 63) begin
                do_reset();
                for (int k = 0; k < 2; k++) begin
                    m_halt[k] = 0; m_wait[k] = 0; m_owed[k] = 0; m_stall[k] = 0; m_flush[k] = 0;
                end
            end
            @(negedge CLK);
            bus.ihit = ($urandom_range(0, 99) < 85);
            bus.dhit = ($urandom_range(0, 99) < 60);
            bus.ifid_rs = 5'($urandom_range(0, 7));
            bus.ifid_rt = 5'($urandom_range(0, 7));
            bus.idex_rs = 5'($urandom_range(0, 7));
            bus.idex_rt = 5'($urandom_range(0, 7));
            bus.idex_writeReg = 5'($urandom_range(0, 7));
            bus.idex_dMemREN = ($urandom_range(0, 99) < 30);
            bus.idex_regWEN = ($urandom_range(0, 1) == 1);
            bus.exmem_writeReg = 5'($urandom_range(0, 7));
            bus.exmem_regWEN = ($urandom_range(0, 1) == 1);
            bus.exmem_dMemREN = ($urandom_range(0, 99) < 20);
            bus.exmem_dMemWEN = ($urandom_range(0, 99) < 15);
            bus.exmem_Halt = ($urandom_range(0, 99) < 2);
            bus.memwb_writeReg = 5'($urandom_range(0, 7));
            bus.memwb_regWEN = ($urandom_range(0, 1) == 1);
            bus.branch_taken = ($urandom_range(0, 99) < 8);
            bus.jump = ($urandom_range(0, 99) < 5);
            #1;
            pend  = bus.exmem_dMemREN | bus.exmem_dMemWEN;
            miss  = pend & ~bus.dhit;
            redir = bus.branch_taken | bus.jump;
            ld    = bus.idex_dMemREN && bus.idex_writeReg != 5'd0 &&
                    (bus.idex_writeReg == bus.ifid_rs || bus.idex_writeReg == bus.ifid_rt);
            n_checks++;
            if (bus.fwdA !== ref_fwd(bus.idex_rs, bus.exmem_writeReg, bus.exmem_regWEN, bus.memwb_writeReg, bus.memwb_regWEN))
                $display("FAIL rnd_fwdA[%0d]: got %b", i, bus.fwdA);
            else n_pass++;
            n_checks++;
            if (bus.fwdB !== ref_fwd(bus.idex_rt, bus.exmem_writeReg, bus.exmem_regWEN, bus.memwb_writeReg, bus.memwb_regWEN))
                $display("FAIL rnd_fwdB[%0d]: got %b", i, bus.fwdB);
            else n_pass++;
            for (int k = 0; k < 2; k++) begin
                st  = get_stat(k);
                est = {m_halt[k] != 0, PERF ? CNT_W'(m_stall[k]) : CNT_W'(0), PERF ? CNT_W'(m_flush[k]) : CNT_W'(0)};
                n_checks++;
                if (st !== est) $display("FAIL rnd_stat[%0d] dut%0d: got %h need %h", i, k, st, est);
                else n_pass++;
                // Reference: halt is sticky; a miss freezes; owed bubbles drain once memory is quiet.
                e = C_IDLE;
                if (m_halt[k] != 0) begin
                    e = C_FREEZE;
                end else if (m_wait[k] == 0 && m_owed[k] == 0 && bus.exmem_Halt && !pend) begin
                    e = C_FREEZE;
                    m_halt[k] = 1;
                    m_stall[k]++;
                end else if (miss) begin
                    e = C_FREEZE;
                    m_wait[k] = 1;
                end else if (m_owed[k] > 0 && m_wait[k] == 0) begin
                    e = C_BUB;
                    m_owed[k]--;
                end else if (m_owed[k] > 0) begin
                    e = bus.ihit ? C_IDLE : C_NOFETCH;
                    m_wait[k] = 0;
                end else begin
                    m_wait[k] = 0;
                    if (redir) begin
                        e = C_REDIR;
                        m_flush[k] = (m_flush[k] + 1) % 16;
                    end else if (ld) begin
                        e = C_BUB;
                        m_owed[k] = k;
                    end else if (!bus.ihit) begin
                        e = C_NOFETCH;
                    end
                end
                if (e[7] == 1'b0 && e != C_FREEZE) m_stall[k]++;
                else if (e == C_FREEZE && m_halt[k] == 0) m_stall[k]++;
                m_stall[k] = m_stall[k] % 16;
                n_checks++;
                if (get_ctl(k) !== e) $display("FAIL rnd_ctl[%0d] dut%0d: got %b need %b", i, k, get_ctl(k), e);
                else n_pass++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_mem_wait();
        test_redirect_vs_lduse();
        test_fwd_priority();
        test_halt();
        test_counters();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
